// File: rtl/ram_array.sv
// ram_array: single-port word RAM with a written-flag per word.
// Reads and writes complete in one cycle with registered outputs. Words
// that were never written read back as zero and report hit=0. An
// out-of-range address raises a one-cycle err pulse and changes nothing.
// preset fills every word with ones and marks it as written. clear is an
// asynchronous reset that wipes contents, flags and outputs.
module ram_array #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             r_w,
    input  logic [AW-1:0]    addr,
    input  logic             preset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             hit,
    output logic             err,
    output logic [AW:0]      used,
    output logic             full
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written;

    logic             in_range;
    logic [AW-1:0]    idx;
    logic             do_write;
    logic [WIDTH-1:0] out_d;
    logic             valid_d;
    logic             hit_d;
    logic             err_d;

    // Decode the access and compute the values the output registers take next.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // branches below leaves one unassigned, which would infer a latch.
        in_range = 1'b0;
        idx      = '0;
        do_write = 1'b0;
        out_d    = '0;
        valid_d  = 1'b0;
        hit_d    = 1'b0;
        err_d    = 1'b0;

        in_range = ({1'b0, addr} < DEPTH_W);
        // Keep the array index legal even when the address is out of range.
        idx      = in_range ? addr : '0;
        do_write = !preset && en && r_w && in_range;

        if (!preset && en) begin
            if (!in_range) begin
                err_d = 1'b1;
            end else if (r_w) begin
                // Write-through: the new data appears on out next cycle.
                out_d   = in;
                valid_d = 1'b1;
                hit_d   = written[idx];
            end else begin
                out_d   = written[idx] ? mem[idx] : '0;
                valid_d = 1'b1;
                hit_d   = written[idx];
            end
        end
    end

    // Storage array and written-flags: fill on preset, store on a write.
    always_ff @(posedge clk or negedge clear) begin
        // NOTE: the array sits inside the async reset because clear must wipe
        // every word immediately; this costs a reset pin per storage bit, so
        // only do it for memories that really must come up cleared.
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: state is updated with non-blocking assignments so all
                // registers see pre-edge values, whatever the statement order.
                mem[i] <= '0;
            end
            written <= '0;
        end else if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '1;
            end
            written <= '1;
        end else if (do_write) begin
            mem[idx]     <= in;
            written[idx] <= 1'b1;
        end
    end

    // Output registers and the distinct-written-word counter.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            out       <= '0;
            out_valid <= 1'b0;
            hit       <= 1'b0;
            err       <= 1'b0;
            used      <= '0;
        end else begin
            out       <= out_d;
            out_valid <= valid_d;
            hit       <= hit_d;
            err       <= err_d;
            if (preset) begin
                used <= DEPTH_W;
            end else if (do_write && !written[idx]) begin
                // Only a first write to a word counts; the flag caps used at DEPTH.
                used <= used + 1'b1;
            end
        end
    end

    // full tracks used combinationally.
    always_comb begin
        full = (used == DEPTH_W);
    end

endmodule

// File: tb/tb_ram_array.sv
// tb_ram_array: drives a DEPTH=8 and a DEPTH=6 instance with the same
// directed and random stimulus. A behavioural model of word contents and
// written flags predicts every registered output, and used is derived by
// counting written flags.
module tb_ram_array;

    logic        clk;
    logic        clear;
    logic        en;
    logic        r_w;
    logic [2:0]  addr;
    logic        preset;
    logic [15:0] din;

    logic [15:0] out8, out6;
    logic        val8, val6, hit8, hit6, err8, err6, full8, full6;
    logic [3:0]  used8, used6;

    ram_array #(.WIDTH(16), .DEPTH(8)) dut8 (
        .clk(clk), .clear(clear), .en(en), .r_w(r_w), .addr(addr),
        .preset(preset), .in(din), .out(out8), .out_valid(val8),
        .hit(hit8), .err(err8), .used(used8), .full(full8)
    );

    ram_array #(.WIDTH(16), .DEPTH(6)) dut6 (
        .clk(clk), .clear(clear), .en(en), .r_w(r_w), .addr(addr),
        .preset(preset), .in(din), .out(out6), .out_valid(val6),
        .hit(hit6), .err(err6), .used(used6), .full(full6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: word contents and written flags for both depths.
    int          depth_of [2] = '{8, 6};
    logic [15:0] mm  [2][8];
    bit          mw  [2][8];
    logic [15:0] exp_out [2];
    bit          exp_val [2];
    bit          exp_hit [2];
    bit          exp_err [2];

    function automatic int count_written(input int k);
        int n = 0;
        for (int i = 0; i < 8; i++) n += mw[k][i] ? 1 : 0;
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                mm[k][i] = '0;
                mw[k][i] = 1'b0;
            end
            exp_out[k] = '0; exp_val[k] = 0; exp_hit[k] = 0; exp_err[k] = 0;
        end
    endtask

    task automatic model_edge(input logic e, input logic rw, input logic [2:0] a,
                              input logic p, input logic [15:0] d);
        for (int k = 0; k < 2; k++) begin
            exp_out[k] = '0; exp_val[k] = 0; exp_hit[k] = 0; exp_err[k] = 0;
            if (p) begin
                for (int i = 0; i < depth_of[k]; i++) begin
                    mm[k][i] = 16'hFFFF;
                    mw[k][i] = 1'b1;
                end
            end else if (e) begin
                if (int'(a) >= depth_of[k]) begin
                    exp_err[k] = 1;
                end else if (rw) begin
                    exp_out[k] = d;
                    exp_val[k] = 1;
                    exp_hit[k] = mw[k][a];
                    mm[k][a]   = d;
                    mw[k][a]   = 1'b1;
                end else begin
                    exp_out[k] = mw[k][a] ? mm[k][a] : 16'h0000;
                    exp_val[k] = 1;
                    exp_hit[k] = mw[k][a];
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        int u;
        u = count_written(0);
        check({tag, " d8 out"},   out8,  exp_out[0]);
        check({tag, " d8 valid"}, val8,  exp_val[0]);
        check({tag, " d8 hit"},   hit8,  exp_hit[0]);
        check({tag, " d8 err"},   err8,  exp_err[0]);
        check({tag, " d8 used"},  used8, u);
        check({tag, " d8 full"},  full8, (u == 8));
        u = count_written(1);
        check({tag, " d6 out"},   out6,  exp_out[1]);
        check({tag, " d6 valid"}, val6,  exp_val[1]);
        check({tag, " d6 hit"},   hit6,  exp_hit[1]);
        check({tag, " d6 err"},   err6,  exp_err[1]);
        check({tag, " d6 used"},  used6, u);
        check({tag, " d6 full"},  full6, (u == 6));
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input string tag, input logic e, input logic rw, input logic [2:0] a,
                        input logic p, input logic [15:0] d);
        en = e; r_w = rw; addr = a; preset = p; din = d;
        @(posedge clk);
        model_edge(e, rw, a, p, d);
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    initial begin
        clear = 1'b0; en = 0; r_w = 0; addr = '0; preset = 0; din = '0;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        clear = 1'b1;

        // Read of a never-written word after reset.
        step("rd_unwritten", 1, 0, 3'd3, 0, 16'h0);

        // Write/read pairs, then a rewrite.
        step("wr0", 1, 1, 3'd0, 0, 16'd45);
        step("wr1", 1, 1, 3'd1, 0, 16'd2047);
        step("rd0", 1, 0, 3'd0, 0, 16'h0);
        check("rd0 value", out8, 16'd45);
        step("rd1", 1, 0, 3'd1, 0, 16'h0);
        check("rd1 value", out8, 16'd2047);
        step("rewr1", 1, 1, 3'd1, 0, 16'd15);
        step("rerd1", 1, 0, 3'd1, 0, 16'h0);
        check("rerd1 used", used8, 4'd2);
        step("idle", 0, 0, 3'd0, 0, 16'h0);

        // Fill every address, keep writing, then preset and read back.
        for (int a = 0; a < 8; a++) step("fill", 1, 1, 3'(a), 0, 16'($urandom));
        check("fill full8", full8, 1'b1);
        step("over", 1, 1, 3'd5, 0, 16'($urandom));
        step("preset", 1, 1, 3'd2, 1, 16'h1234);
        for (int a = 0; a < 8; a++) step("post_preset", 1, 0, 3'(a), 0, 16'h0);

        // Out-of-range write on the DEPTH=6 instance, then idle.
        step("oor7", 1, 1, 3'd7, 0, 16'd31);
        check("oor7 err6", err6, 1'b1);
        step("oor_idle", 0, 0, 3'd7, 0, 16'h0);

        // Fresh start, then randomized traffic.
        clear = 1'b0;
        #1;
        model_reset();
        compare_all("reset2");
        @(negedge clk);
        clear = 1'b1;
        for (int n = 0; n < 400; n++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 40) == 0), 16'($urandom));
        end

        // Reset asserted between edges during a write burst.
        for (int a = 0; a < 4; a++) step("burst", 1, 1, 3'(a), 0, 16'($urandom));
        en = 1; r_w = 1; addr = 3'd4; preset = 0; din = 16'hBEEF;
        #2;
        clear = 1'b0;
        #1;
        model_reset();
        compare_all("midrst");
        @(posedge clk);
        #1;
        compare_all("rsthold");
        @(negedge clk);
        en = 0;
        clear = 1'b1;
        for (int a = 0; a < 6; a++) step("after_rst", 1, 0, 3'(a), 0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_array.md
RAM_ARRAY -- requirements
Module: ram_array

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of words (2..256, any integer).
REQ-003 The block SHALL have parameter AW, default ceil(log2(DEPTH)), meaning address width.
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge except reset.
REQ-005 The block SHALL have port clear  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port en  input  1  chip select; 0 = idle cycle.
REQ-007 The block SHALL have port r_w  input  1  1 = write, 0 = read; sampled only when en=1.
REQ-008 The block SHALL have port addr  input  AW  word address.
REQ-009 The block SHALL have port preset  input  1  synchronous fill-all-ones command.
REQ-010 The block SHALL have port in  input  WIDTH  write data.
REQ-011 The block SHALL have port out  output  WIDTH  registered read data.
REQ-012 The block SHALL have port out_valid  output  1  out holds data from an accepted access.
REQ-013 The block SHALL have port hit  output  1  accessed word had been written since reset.
REQ-014 The block SHALL have port err  output  1  one-cycle pulse for out-of-range address.
REQ-015 The block SHALL have port used  output  AW+1  count of distinct written words.
REQ-016 The block SHALL have port full  output  1  used == DEPTH.

Function
REQ-017 Storage SHALL be DEPTH words of WIDTH bits plus one written-flag per word.
REQ-018 Priority at a rising edge SHALL be: preset, then en access, then idle.
REQ-019 Write (en=1, r_w=1, addr<DEPTH) SHALL store in at addr, set written[addr], and drive out<=in, out_valid<=1, hit<=prior written[addr] (write-through, 1-cycle latency).
REQ-020 Read (en=1, r_w=0, addr<DEPTH) SHALL drive out<=mem[addr] if written[addr] else 0, out_valid<=1, hit<=written[addr]; memory unchanged.
REQ-021 Read latency SHALL be exactly one cycle; back-to-back accesses every cycle SHALL be supported.
REQ-022 Read of an address written in the previous cycle SHALL return the new data.
REQ-023 Idle (en=0, preset=0) SHALL drive out<=0, out_valid<=0, hit<=0, err<=0; memory unchanged.
REQ-024 Out-of-range access (en=1, addr>=DEPTH) SHALL leave memory and flags unchanged and drive out<=0, out_valid<=0, hit<=0, err<=1 for one cycle.
REQ-025 used SHALL increment by 1 on a write to a word whose flag was 0, stay unchanged on rewrite, never exceed DEPTH and never decrement except via reset.
REQ-026 full SHALL be combinationally equal to (used == DEPTH).
REQ-027 preset=1 SHALL set every word to all ones, set every flag, set used<=DEPTH, and drive out<=0, out_valid<=0, hit<=0, err<=0, ignoring en/r_w/addr/in that cycle.
REQ-028 err SHALL be 0 in every cycle not following an out-of-range access.

Reset
REQ-029 clear=0 SHALL immediately, without a clock edge, clear all words to 0, all flags to 0, used to 0, and out, out_valid, hit, err to 0.
REQ-030 Reset asserted mid-access SHALL abort it; no write of that cycle SHALL persist.
REQ-031 After clear returns to 1, the first rising edge SHALL be processed normally.

Verification (WIDTH=16, DEPTH=8 unless noted)
REQ-032 Reset then read addr 3 -> out=0, out_valid=1, hit=0, used=0.
REQ-033 Write 45 @addr0, write 2047 @addr1, read 0, read 1 -> out 45, 2047, 45, 2047 on consecutive cycles; hit 0,0,1,1; used=2.
REQ-034 Rewrite addr1 with 15, then read 1 -> out=15, hit=1 on the rewrite and the read; used stays 2.
REQ-035 Write all 8 addresses -> used=8, full=1; further writes keep used=8; preset -> all reads return 16'hFFFF, hit=1.
REQ-036 DEPTH=6: write addr 7 with 31 -> err=1 one cycle, out_valid=0, used unchanged; idle cycle -> err=0.
REQ-037 Assert clear between clock edges during a write burst -> all outputs 0 at once; subsequent reads return 0 with hit=0.
